// File: rtl/status_uart_tx.sv
// Status frame transmitter: snapshots {flags, counter} on a send request and
// shifts it out as four back-to-back 8N1 bytes (header first, then three
// 7-bit counter groups, LSB group first).
//
// Handshake: send is a level sampled every clk. When the FSM is idle a send
// is accepted at that edge. When busy, a send arms a single pending request;
// further sends are dropped until the pending request is consumed at the end
// of the frame. A send in the frame's last cycle counts as the pending request.
module status_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [6:0]  flags,
  input  logic [20:0] counter,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic [27:0]       snap_q, snap_d;   // {counter, flags}
  logic              pend_q, pend_d;
  logic              tx_q, tx_d;

  logic              bit_end;
  logic              frame_end;
  logic [7:0]        cur_byte;

  // Byte k of the frame, built from a snapshot.
  function automatic logic [7:0] frame_byte(input logic [27:0] s, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {1'b1, s[6:0]};
      2'd1:    b = {1'b0, s[13:7]};
      2'd2:    b = {1'b0, s[20:14]};
      default: b = {1'b0, s[27:21]};
    endcase
    return b;
  endfunction

  assign bit_end   = (cnt_q == CNT_LAST);
  assign frame_end = (state_q == S_STOP) && (byte_q == 2'd3) && bit_end;

  // Next-state, baud/bit/byte counters, snapshot, pending flag and next tx level.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    snap_d   = snap_q;
    pend_d   = pend_q;
    tx_d     = 1'b1;
    cur_byte = 8'h00;

    if ((state_q != S_IDLE) && send) begin
      pend_d = 1'b1;
    end

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (send) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          snap_d  = {counter, flags};
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_q == 2'd3) begin
            // Frame end: a pending or same-cycle request restarts with no gap.
            pend_d = 1'b0;
            byte_d = 2'd0;
            bit_d  = 3'd0;
            if (pend_q || send) begin
              state_d = S_START;
              snap_d  = {counter, flags};
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_START;
            byte_d  = byte_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered, so its next value follows the next bit position.
    cur_byte = frame_byte(snap_d, byte_d);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State register with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      snap_q  <= 28'd0;
      pend_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);
  assign done = frame_end & ~rst;

endmodule

// File: tb/tb_status_uart_tx.sv
// Bench for status_uart_tx: two instances (4 and 1 clocks per bit) checked
// every cycle against a frame-level reference model, plus directed decodes.
module tb_status_uart_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [2];
  logic        send_v  [2];
  logic [6:0]  flags_v [2];
  logic [20:0] counter_v [2];
  logic        tx0, busy0, done0, tx1, busy1, done1;

  status_uart_tx #(.CLKS_PER_BIT(4), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst_v[0]), .send(send_v[0]), .flags(flags_v[0]),
    .counter(counter_v[0]), .tx(tx0), .busy(busy0), .done(done0)
  );

  status_uart_tx #(.CLKS_PER_BIT(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst_v[1]), .send(send_v[1]), .flags(flags_v[1]),
    .counter(counter_v[1]), .tx(tx1), .busy(busy1), .done(done1)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // expected decoded bytes for directed frames
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int cpb(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [6:0] f, input logic [20:0] c, input int j);
    case (j)
      0:       return {1'b1, f};
      1:       return {1'b0, c[6:0]};
      2:       return {1'b0, c[13:7]};
      default: return {1'b0, c[20:14]};
    endcase
  endfunction

  // Line level for each of the 40 bit times of a frame.
  function automatic logic [39:0] enc(input logic [6:0] f, input logic [20:0] c);
    logic [39:0] r;
    logic [7:0]  b;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      b = exp_byte(f, c, j);
      r[10*j] = 1'b0;
      for (int i = 0; i < 8; i++) r[10*j+1+i] = b[i];
      r[10*j+9] = 1'b1;
    end
    return r;
  endfunction

  bit          act  [2];
  bit          pend [2];
  int          rem  [2];
  logic [39:0] frm  [2];

  task automatic start_frame(input int k);
    frm[k] = enc(flags_v[k], counter_v[k]);
    rem[k] = 40 * cpb(k);
    act[k] = 1'b1;
  endtask

  task automatic model_step(input int k);
    bit last;
    last = act[k] && (rem[k] == 1);
    if (rst_v[k]) begin
      act[k] = 1'b0; pend[k] = 1'b0; rem[k] = 0;
    end else if (act[k]) begin
      if (last) begin
        if (pend[k] || send_v[k]) begin
          start_frame(k);
          pend[k] = 1'b0;
        end else begin
          act[k] = 1'b0; rem[k] = 0;
        end
      end else begin
        rem[k]--;
        if (send_v[k]) pend[k] = 1'b1;
      end
    end else if (send_v[k]) begin
      start_frame(k);
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- per-cycle scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic etx, ebusy, edone;
        int   n;
        n     = 40 * cpb(k);
        etx   = act[k] ? frm[k][(n - rem[k]) / cpb(k)] : 1'b1;
        ebusy = act[k];
        edone = act[k] && (rem[k] == 1) && !rst_v[k];
        if (k == 0) begin
          check("tx0",   32'(tx0),   32'(etx));
          check("busy0", 32'(busy0), 32'(ebusy));
          check("done0", 32'(done0), 32'(edone));
        end else begin
          check("tx1",   32'(tx1),   32'(etx));
          check("busy1", 32'(busy1), 32'(ebusy));
          check("done1", 32'(done1), 32'(edone));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_send0();
    send_v[0] = 1'b1;
    @(posedge clk); #1;
    send_v[0] = 1'b0;
  endtask

  // Record 160 cycles of dut0 starting with the cycle after the accept edge.
  task automatic capture(input int chg_at, output logic [159:0] t,
                         output int done_at, output int ndone);
    done_at = -1; ndone = 0; t = '0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (i == chg_at) counter_v[0] = 21'h0;
      t[i] = tx0;
      if (done0) begin ndone++; done_at = i; end
    end
  endtask

  function automatic logic [7:0] dec(input logic [159:0] t, input int j);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = t[40*j + 4*(i+1) + 2];
    return b;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [159:0] t;
    int done_at, ndone, nbusy, last_done, nd;
    logic [6:0]  f;
    logic [20:0] c;

    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; send_v[k] = 1'b1; flags_v[k] = '0; counter_v[k] = '0;
    end

    // 1: reset held 3 cycles with send high
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin rst_v[k] = 1'b0; send_v[k] = 1'b0; end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_after_rst_busy", 32'(busy0), 32'd0);
      check("idle_after_rst_tx",   32'(tx0),   32'd1);
    end
    @(posedge clk); #1;

    // 2: encoding
    flags_v[0] = 7'h15; counter_v[0] = 21'h1ABCDE;
    exp_q.push_back(8'h95); exp_q.push_back(8'h5E);
    exp_q.push_back(8'h79); exp_q.push_back(8'h6A);
    pulse_send0();
    capture(-1, t, done_at, ndone);
    for (int j = 0; j < 4; j++) check("enc_byte", 32'(dec(t, j)), 32'(exp_q.pop_front()));
    check("enc_start_low", 32'(t[4:0]), 32'h10);
    check("enc_done_cnt", 32'(ndone), 32'd1);
    check("enc_done_at",  32'(done_at), 32'd159);
    repeat (3) @(posedge clk); #1;

    // 3: snapshot holds while counter changes in B1
    counter_v[0] = 21'h1ABCDE;
    pulse_send0();
    capture(50, t, done_at, ndone);
    check("snap_b1", 32'(dec(t, 1)), 32'h5E);
    check("snap_b2", 32'(dec(t, 2)), 32'h79);
    check("snap_b3", 32'(dec(t, 3)), 32'h6A);
    repeat (3) @(posedge clk); #1;

    // 4: pending - three extra sends during a frame give exactly two frames
    pulse_send0();
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      send_v[0] = (i == 30 || i == 60 || i == 90);
      if (!busy0) break;
      nbusy++;
      if (done0) ndone++;
    end
    send_v[0] = 1'b0;
    check("pend_busy_len", 32'(nbusy), 32'd320);
    check("pend_done_cnt", 32'(ndone), 32'd2);
    @(posedge clk); #1;

    // 5: abort in B1 data, then a fresh full frame
    flags_v[0] = 7'($urandom); counter_v[0] = 21'($urandom);
    pulse_send0();
    repeat (49) @(negedge clk);
    @(posedge clk); #1 rst_v[0] = 1'b1;
    @(posedge clk); #1 rst_v[0] = 1'b0;
    @(negedge clk);
    check("abort_tx",   32'(tx0),   32'd1);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_done", 32'(done0), 32'd0);
    @(posedge clk); #1;
    f = 7'($urandom); c = 21'($urandom);
    flags_v[0] = f; counter_v[0] = c;
    for (int j = 0; j < 4; j++) exp_q.push_back(exp_byte(f, c, j));
    pulse_send0();
    flags_v[0] = ~f; counter_v[0] = ~c;
    capture(-1, t, done_at, ndone);
    for (int j = 0; j < 4; j++) check("abort_new_byte", 32'(dec(t, j)), 32'(exp_q.pop_front()));
    check("abort_new_done_at", 32'(done_at), 32'd159);

    // 6: CLKS_PER_BIT=1, send held high
    @(posedge clk); #1;
    flags_v[1] = 7'($urandom); counter_v[1] = 21'($urandom);
    send_v[1] = 1'b1;
    last_done = -1; nd = 0;
    for (int i = 0; i < 205; i++) begin
      @(negedge clk);
      if (done1) begin
        if (last_done >= 0) check("cont_done_period", 32'(i - last_done), 32'd40);
        last_done = i;
        nd++;
      end
    end
    check("cont_done_cnt", 32'(nd), 32'd5);
    @(posedge clk); #1 send_v[1] = 1'b0;
    repeat (100) @(posedge clk); #1;

    // random phase
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) begin
        send_v[k]    = ($urandom_range(0, 29) == 0);
        flags_v[k]   = 7'($urandom);
        counter_v[k] = 21'($urandom);
        rst_v[k]     = ($urandom_range(0, 399) == 0);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin send_v[k] = 1'b0; rst_v[k] = 1'b0; end
    repeat (400) @(posedge clk);
    @(negedge clk);
    check("final_idle0", 32'(busy0), 32'd0);
    check("final_idle1", 32'(busy1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
